uart_rx_os: RTL
===============

# uart_rx_os

Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver feeding the MIPS debug unit. It takes the oversampling tick from `baudrate_generator` and the raw `i_rx` line, and outputs one data word per frame with a single-cycle done strobe. It adds four things the fixed receiver lacks:
- configurable data width, oversampling ratio and stop-bit count;
- a 3-sample majority filter;
- start-bit glitch rejection;
- framing and, optionally, parity error flags.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5–9.
- `OVERSAMPLING`, 16: ticks per bit, even, legal 8–32.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Used only with `UART_RX_PARITY_EN`.

Ports:
- `clk`, in, 1: system clock (100 MHz). Single clock domain.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_tick`, in, 1: oversampling tick, one `clk` wide, OVERSAMPLING per bit period.
- `i_rx`, in, 1: asynchronous serial line, idle high.
- `o_data`, out, DATA_BITS: received word, LSB first on the line.
- `o_rx_done`, out, 1: one-cycle strobe, a frame has completed.
- `o_frame_err`, out, 1: stop bit sampled low. Valid with `o_rx_done`.
- `o_parity_err`, out, 1: parity mismatch. Valid with `o_rx_done`. Tied 0 when the feature is compiled out.
- `o_busy`, out, 1: high in every state except IDLE.

## Operation
Input conditioning:
- `i_rx` passes through a 2-flop synchronizer to give `rx_s`.
- On every `i_tick`, `rx_s` shifts into a 3-bit history.
- `rx_f` is the majority of that 3-bit history.
- Reset loads the synchronizer and the history with 1s.

State machine: IDLE, START, DATA, PARITY, STOP. A tick counter and a bit counter run inside the states.
- **IDLE**: a falling edge on `rx_s` (previous 1, current 0), sampled on any `clk`, moves to START and clears the tick counter.
- **START**: counts ticks.
  - When the count reaches OVERSAMPLING/2−1, check `rx_f`.
  - `rx_f`=0: clear the counter and go to DATA.
  - `rx_f`=1: glitch; return to IDLE with no strobe.
- **DATA**: every OVERSAMPLING ticks, shift `rx_f` into the MSB of the shift register (right shift).
  - After DATA_BITS samples, go to PARITY if the feature is enabled, otherwise STOP.
- **PARITY**: after OVERSAMPLING ticks, sample the parity bit and go to STOP.
- **STOP**: sample STOP_BITS times, each OVERSAMPLING ticks apart. Any low sample latches a frame error.
  - On the last sample, load `o_data` and set the error flags.
  - Pulse `o_rx_done` and return to IDLE.
- Data is delivered even when an error flag is set. The consumer decides whether to discard it.
- A break (line held low) gives one frame with data 0 and `o_frame_err`=1.
  - A new start needs a fresh 1→0 edge, so a held-low line produces no further frames.
- `i_rst` at any cycle, including mid-frame, returns to IDLE. No strobe is produced.

## Timing
Reset values:
- `o_data`=0, `o_rx_done`=0, `o_frame_err`=0, `o_parity_err`=0, `o_busy`=0.

Latencies:
- Falling edge on `i_rx` to START: 3 `clk` (2 synchronizer flops plus edge register).
- `o_rx_done` rises on the `clk` after the `i_tick` that samples the last stop bit, and lasts exactly 1 cycle.

Output hold:
- `o_data` and the error flags hold until the next `o_rx_done`.
- The error flags are cleared only when the next frame loads.

Counters:
- The tick counter is ceil(log2(OVERSAMPLING)) bits wide and wraps to 0 at OVERSAMPLING−1.
- The bit counter is ceil(log2(DATA_BITS+1)) bits wide.

Tick and input rules:
- `i_tick` is ignored in IDLE.
- When `i_tick` and a `rx_s` edge arrive in the same cycle, the edge wins. The counter starts at 0 and that tick is not counted.

## Configuration
Macro `UART_RX_PARITY_EN`:
- **Defined**: the PARITY state exists.
  - The expected bit is the XOR of the data bits, inverted when PARITY_ODD=1.
  - A mismatch sets `o_parity_err` with `o_rx_done`.
- **Undefined**: no PARITY state and DATA goes directly to STOP. `o_parity_err` is tied 0, and frame length is 1+DATA_BITS+STOP_BITS bits.

## Structure
Package `uart_pkg` holds:
- the state enum;
- the default OVERSAMPLING, DATA_BITS and STOP_BITS constants;
- the `clog2` helper.

Sub-module `rx_sync_filter`: the synchronizer, edge detect and majority vote. Outputs `rx_s`, `rx_fall` and `rx_f`.

## Test plan
Bench: `i_tick` every 4 `clk`, OVERSAMPLING=16, so 64 `clk` per bit.
- Frames 0x20, 0x01, 0x00, 0x0F, 8N1 → four `o_rx_done` strobes, one cycle each, with `o_data` matching in order and both error flags 0.
- A 0xD5 frame with the stop bit forced low, then idle → `o_data`=0xD5, `o_frame_err`=1. The next clean 0x55 clears the flag.
- A 2-tick low glitch on an idle line → no strobe, and `o_busy` returns to 0 within 8 ticks.
- A single-tick inverted spike at mid-bit of every data bit while sending 0xC4 → `o_data`=0xC4 (majority filter).
- With `UART_RX_PARITY_EN`, DATA_BITS=7, even parity: 0x55 with correct parity → err 0. The same frame with parity flipped → `o_parity_err`=1.
- `i_rst` asserted for 1 cycle in the middle of data bit 3 of 0xEE → all outputs 0 and no strobe. The following 0xEE is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int DEF_OVERSAMPLING = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_STOP_BITS    = 1;

    // ceil(log2(value)), never narrower than one bit
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rx_sync_filter.sv
// Input conditioning for uart_rx_os: 2-flop synchronizer, falling-edge detect
// on the synchronized line, and a 3-sample majority vote clocked by i_tick.
module rx_sync_filter (
    input  logic clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_rx,
    output logic rx_s,
    output logic rx_fall,
    output logic rx_f
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [2:0] hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[0], i_rx};
        prev_d = sync_q[1];
        hist_d = hist_q;
        if (i_tick) begin
            hist_d = {hist_q[1:0], sync_q[1]};
        end
    end

    // Everything resets to the idle (high) line level so no false edge follows reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            hist_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            hist_q <= hist_d;
        end
    end

    assign rx_s    = sync_q[1];
    assign rx_fall = prev_q & ~sync_q[1];
    assign rx_f    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority filter, glitch rejection and framing check.
// Define UART_RX_PARITY_EN to add a parity bit after the data and the o_parity_err flag.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int OVERSAMPLING = DEF_OVERSAMPLING,
    parameter int STOP_BITS    = DEF_STOP_BITS
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int TW = clog2(OVERSAMPLING);
    localparam int BW = clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic rx_s, rx_fall, rx_f;

    rx_sync_filter u_filter (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_tick  (i_tick),
        .i_rx    (i_rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall),
        .rx_f    (rx_f)
    );

    rx_state_e             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic                  frame_err_q, frame_err_d;
    logic                  done_q, done_d;
    logic                  bit_time;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  parity_err_q, parity_err_d;
`endif

    assign bit_time = i_tick && (tick_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ferr_acc_d  = ferr_acc_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = parity_err_q;
`endif
        if (state_q != ST_IDLE && state_q != ST_START && i_tick) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_fall && !rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d     = '0;
                        bit_d      = '0;
                        ferr_acc_d = 1'b0;
                        state_d    = rx_f ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_time) begin
                    shift_d = {rx_f, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_time) begin
                    par_bit_d = rx_f;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Each stop sample can flag a framing error; the last one publishes the frame
                if (bit_time) begin
                    if (bit_q == STOP_LAST) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        data_d      = shift_q;
                        frame_err_d = ferr_acc_q | ~rx_f;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bit_q ^ (^shift_q) ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        bit_d      = bit_q + 1'b1;
                        ferr_acc_d = ferr_acc_q | ~rx_f;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Frame-local working state, always rewritten before it is used
    always_ff @(posedge clk) begin
        shift_q    <= shift_d;
        ferr_acc_q <= ferr_acc_d;
`ifdef UART_RX_PARITY_EN
        par_bit_q  <= par_bit_d;
`endif
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
